// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle MIPS-subset control unit.
// Latches the fetched word into IR and walks FETCH/DECODE/EXEC/MEM/WB, with one
// pcEn pulse per retired instruction and a bus-wait watchdog (WAIT_LIMIT, 0 = off).
// Optional feature macro: CU_PERF_CNT_EN adds the instret/cycles counter ports.
module mc_control_unit #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned REG_W      = 5,
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] ins,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              zf,
  output logic              iREN,
  output logic              dREN,
  output logic              dWEN,
  output logic              pcEn,
  output logic [1:0]        pcSel,
  output logic [1:0]        aluBSel,
  output logic [1:0]        rfInSel,
  output logic [3:0]        op,
  output logic [REG_W-1:0]  wsel,
  output logic [REG_W-1:0]  rsel1,
  output logic [REG_W-1:0]  rsel2,
  output logic              WEN,
  output logic [WORD_W-1:0] shamt,
  output logic [WORD_W-1:0] ext32,
  output logic [25:0]       immJ26,
  output logic              halt,
  output logic              timeout
`ifdef CU_PERF_CNT_EN
  ,
  output logic [WORD_W-1:0] instret,
  output logic [WORD_W-1:0] cycles
`endif
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;

  localparam logic [1:0] PC_PC4    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_JR     = 2'd3;

  localparam logic [1:0] B_RT    = 2'd0;
  localparam logic [1:0] B_EXT32 = 2'd1;
  localparam logic [1:0] B_SHAMT = 2'd2;

  localparam logic [1:0] RF_ALU = 2'd0;
  localparam logic [1:0] RF_MEM = 2'd1;
  localparam logic [1:0] RF_LUI = 2'd2;
  localparam logic [1:0] RF_PC4 = 2'd3;

  localparam logic [3:0] OP_SLL  = 4'd0;
  localparam logic [3:0] OP_SRL  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  // instruction classes
  localparam logic [3:0] C_ALU_R = 4'd0;
  localparam logic [3:0] C_ALU_I = 4'd1;
  localparam logic [3:0] C_LUI   = 4'd2;
  localparam logic [3:0] C_LW    = 4'd3;
  localparam logic [3:0] C_SW    = 4'd4;
  localparam logic [3:0] C_BEQ   = 4'd5;
  localparam logic [3:0] C_BNE   = 4'd6;
  localparam logic [3:0] C_J     = 4'd7;
  localparam logic [3:0] C_JR    = 4'd8;
  localparam logic [3:0] C_JAL   = 4'd9;
  localparam logic [3:0] C_HALT  = 4'd10;
  localparam logic [3:0] C_BAD   = 4'd11;

  localparam int unsigned CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

  logic [2:0]        state, next_state;
  logic [WORD_W-1:0] ir;
  logic [5:0]        opcode, funct;
  logic [3:0]        cls;
  logic              zext;
  logic              ir_load;
  logic              wd_fire;
  logic              wd_expire;
  logic              wait_active;
  logic [CNT_W-1:0]  wait_cnt;

  assign opcode = ir[31:26];
  assign funct  = ir[5:0];

  // IR field fan-out to the datapath
  assign rsel1  = REG_W'(ir[25:21]);
  assign rsel2  = REG_W'(ir[20:16]);
  assign immJ26 = ir[25:0];
  assign shamt  = {{(WORD_W-5){1'b0}}, ir[10:6]};
  assign ext32  = zext ? {{(WORD_W-16){1'b0}}, ir[15:0]}
                       : {{(WORD_W-16){ir[15]}}, ir[15:0]};

  // Watchdog: expires on the WAIT_LIMIT-th consecutive wait cycle
  assign wait_active = ((state == S_FETCH) && !ihit) || ((state == S_MEM) && !dhit);
  assign wd_expire   = (WAIT_LIMIT != 0) && (wait_cnt == CNT_W'(WAIT_LIMIT - 1));

  // Instruction decode from IR: class, ALU op, B-operand source, immediate extension
  always_comb begin
    cls     = C_BAD;
    op      = OP_ADD;
    aluBSel = B_RT;
    zext    = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h00:        begin cls = C_ALU_R; op = OP_SLL;  aluBSel = B_SHAMT; end
          6'h02:        begin cls = C_ALU_R; op = OP_SRL;  aluBSel = B_SHAMT; end
          6'h08:        cls = C_JR;
          6'h20, 6'h21: begin cls = C_ALU_R; op = OP_ADD;  end
          6'h22, 6'h23: begin cls = C_ALU_R; op = OP_SUB;  end
          6'h24:        begin cls = C_ALU_R; op = OP_AND;  end
          6'h25:        begin cls = C_ALU_R; op = OP_OR;   end
          6'h26:        begin cls = C_ALU_R; op = OP_XOR;  end
          6'h27:        begin cls = C_ALU_R; op = OP_NOR;  end
          6'h2A:        begin cls = C_ALU_R; op = OP_SLT;  end
          6'h2B:        begin cls = C_ALU_R; op = OP_SLTU; end
          default:      cls = C_BAD;
        endcase
      end
      6'h02:        cls = C_J;
      6'h03:        cls = C_JAL;
      6'h04:        begin cls = C_BEQ;   op = OP_SUB; end
      6'h05:        begin cls = C_BNE;   op = OP_SUB; end
      6'h08, 6'h09: begin cls = C_ALU_I; op = OP_ADD;  aluBSel = B_EXT32; end
      6'h0A:        begin cls = C_ALU_I; op = OP_SLT;  aluBSel = B_EXT32; end
      6'h0B:        begin cls = C_ALU_I; op = OP_SLTU; aluBSel = B_EXT32; end
      6'h0C:        begin cls = C_ALU_I; op = OP_AND;  aluBSel = B_EXT32; zext = 1'b1; end
      6'h0D:        begin cls = C_ALU_I; op = OP_OR;   aluBSel = B_EXT32; zext = 1'b1; end
      6'h0E:        begin cls = C_ALU_I; op = OP_XOR;  aluBSel = B_EXT32; zext = 1'b1; end
      6'h0F:        begin cls = C_LUI;   aluBSel = B_EXT32; zext = 1'b1; end
      6'h23:        begin cls = C_LW;    op = OP_ADD;  aluBSel = B_EXT32; end
      6'h2B:        begin cls = C_SW;    op = OP_ADD;  aluBSel = B_EXT32; end
      6'h3F:        cls = C_HALT;
      default:      cls = C_BAD;
    endcase
  end

  // Write-back register and source select
  always_comb begin
    wsel    = REG_W'(ir[20:16]);
    rfInSel = RF_ALU;
    case (cls)
      C_ALU_R: wsel = REG_W'(ir[15:11]);
      C_JAL:   begin wsel = REG_W'(31); rfInSel = RF_PC4; end
      C_LW:    rfInSel = RF_MEM;
      C_LUI:   rfInSel = RF_LUI;
      default: rfInSel = RF_ALU;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= S_FETCH;
    else     state <= next_state;
  end

  // Next-state and strobe generation
  always_comb begin
    next_state = state;
    iREN       = 1'b0;
    dREN       = 1'b0;
    dWEN       = 1'b0;
    pcEn       = 1'b0;
    WEN        = 1'b0;
    pcSel      = PC_PC4;
    ir_load    = 1'b0;
    wd_fire    = 1'b0;
    halt       = 1'b0;
    case (state)
      S_FETCH: begin
        iREN = 1'b1;
        if (ihit) begin
          ir_load    = 1'b1;
          next_state = S_DECODE;
        end else if (wd_expire) begin
          wd_fire    = 1'b1;
          next_state = S_HALTED;
        end
      end
      S_DECODE: begin
        if ((cls == C_HALT) || (cls == C_BAD)) next_state = S_HALTED;
        else                                   next_state = S_EXEC;
      end
      S_EXEC: begin
        case (cls)
          C_ALU_R, C_ALU_I, C_LUI, C_JAL: next_state = S_WB;
          C_LW, C_SW:                     next_state = S_MEM;
          C_BEQ: begin
            pcEn       = 1'b1;
            pcSel      = zf ? PC_BRANCH : PC_PC4;
            next_state = S_FETCH;
          end
          C_BNE: begin
            pcEn       = 1'b1;
            pcSel      = zf ? PC_PC4 : PC_BRANCH;
            next_state = S_FETCH;
          end
          C_J: begin
            pcEn       = 1'b1;
            pcSel      = PC_JUMP;
            next_state = S_FETCH;
          end
          C_JR: begin
            pcEn       = 1'b1;
            pcSel      = PC_JR;
            next_state = S_FETCH;
          end
          default: next_state = S_HALTED;
        endcase
      end
      S_MEM: begin
        if (cls == C_LW) dREN = 1'b1;
        else             dWEN = 1'b1;
        if (dhit) begin
          if (cls == C_LW) begin
            next_state = S_WB;
          end else begin
            pcEn       = 1'b1;
            next_state = S_FETCH;
          end
        end else if (wd_expire) begin
          wd_fire    = 1'b1;
          next_state = S_HALTED;
        end
      end
      S_WB: begin
        WEN        = 1'b1;
        pcEn       = 1'b1;
        pcSel      = (cls == C_JAL) ? PC_JUMP : PC_PC4;
        next_state = S_FETCH;
      end
      S_HALTED: halt = 1'b1;
      default:  next_state = S_FETCH;
    endcase
  end

  // IR capture, watchdog counter and sticky timeout flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      ir       <= '0;
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (ir_load) ir <= ins;
      if (wd_fire) timeout <= 1'b1;
      if (wait_active && (next_state == state)) wait_cnt <= wait_cnt + CNT_W'(1);
      else                                      wait_cnt <= '0;
    end
  end

`ifdef CU_PERF_CNT_EN
  // Retired-instruction and active-cycle counters; cycles freezes once halted
  always_ff @(posedge CLK) begin
    if (RST) begin
      instret <= '0;
      cycles  <= '0;
    end else begin
      if (pcEn) instret <= instret + WORD_W'(1);
      if (state != S_HALTED) cycles <= cycles + WORD_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: directed scoreboard bench for mc_control_unit (WAIT_LIMIT=8).
// Define CU_PERF_CNT_EN for both files to exercise the counter ports.
module tb_mc_control_unit;

  localparam logic [1:0] PC_PC4 = 2'd0, PC_BRANCH = 2'd1, PC_JUMP = 2'd2, PC_JR = 2'd3;
  localparam logic [1:0] B_RT = 2'd0, B_EXT32 = 2'd1, B_SHAMT = 2'd2;
  localparam logic [1:0] RF_ALU = 2'd0, RF_MEM = 2'd1, RF_LUI = 2'd2, RF_PC4 = 2'd3;
  localparam logic [3:0] OP_SLL = 4'd0, OP_ADD = 4'd2, OP_SUB = 4'd3, OP_OR = 4'd5;

  typedef struct packed {
    logic [7:0]  lat;
    logic        wen;
    logic [4:0]  wsel;
    logic [1:0]  pcsel;
    logic [1:0]  rfin;
    logic        ck_op;
    logic [3:0]  op;
    logic [1:0]  bsel;
    logic        ck_ext;
    logic [31:0] ext;
    logic [3:0]  memn;
  } exp_t;

  logic        CLK, RST, ihit, dhit, zf;
  logic [31:0] ins;
  logic        iREN, dREN, dWEN, pcEn, WEN, halt, timeout;
  logic [1:0]  pcSel, aluBSel, rfInSel;
  logic [3:0]  op;
  logic [4:0]  wsel, rsel1, rsel2;
  logic [31:0] shamt, ext32;
  logic [25:0] immJ26;
`ifdef CU_PERF_CNT_EN
  logic [31:0] instret, cycles;
`endif

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  logic [4:0]  s_rsel1, s_rsel2;
  logic [31:0] s_shamt;
  logic [25:0] s_imm;

  mc_control_unit #(.WORD_W(32), .REG_W(5), .WAIT_LIMIT(8)) dut (
    .CLK(CLK), .RST(RST), .ins(ins), .ihit(ihit), .dhit(dhit), .zf(zf),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .pcEn(pcEn), .pcSel(pcSel),
    .aluBSel(aluBSel), .rfInSel(rfInSel), .op(op), .wsel(wsel),
    .rsel1(rsel1), .rsel2(rsel2), .WEN(WEN), .shamt(shamt), .ext32(ext32),
    .immJ26(immJ26), .halt(halt), .timeout(timeout)
`ifdef CU_PERF_CNT_EN
    , .instret(instret), .cycles(cycles)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input int lat, input logic wen, input logic [4:0] ws,
                              input logic [1:0] pcs, input logic [1:0] rfin,
                              input logic ck_op, input logic [3:0] o, input logic [1:0] bs,
                              input logic ck_ext, input logic [31:0] ext, input int memn);
    exp_t e;
    e.lat = 8'(lat); e.wen = wen; e.wsel = ws; e.pcsel = pcs; e.rfin = rfin;
    e.ck_op = ck_op; e.op = o; e.bsel = bs; e.ck_ext = ck_ext; e.ext = ext;
    e.memn = 4'(memn);
    return e;
  endfunction

  // Leaves the bench at a negedge with RST low and the DUT in FETCH
  task automatic do_reset();
    RST = 1'b1; ihit = 1'b0; dhit = 1'b0; zf = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Runs one instruction from its FETCH cycle until pcEn and scores it
  task automatic run_instr(input string tag, input logic [31:0] word, input logic zf_v,
                           input int dwait, input exp_t e);
    exp_t x;
    int cyc, memn, wenn;
    logic done, wen_s;
    logic [4:0] wsel_s;
    logic [1:0] pcs_s, rfin_s, bsel_s;
    logic [3:0] op_s;
    logic [31:0] ext_s;
    sb.push_back(e);
    ins = word; zf = zf_v;
    cyc = 0; memn = 0; wenn = 0; done = 1'b0;
    wen_s = 1'b0; wsel_s = '0; pcs_s = '0; rfin_s = '0; bsel_s = '0; op_s = '0; ext_s = '0;
    while (!done && cyc < 40) begin
      cyc++;
      ihit = (cyc == 1);
      dhit = (dREN || dWEN) && (memn + 1 >= dwait);
      #1;
      if (dREN || dWEN) memn++;
      if (WEN) wenn++;
      if (cyc == 3) begin
        op_s = op; bsel_s = aluBSel; ext_s = ext32;
        s_rsel1 = rsel1; s_rsel2 = rsel2; s_shamt = shamt; s_imm = immJ26;
      end
      if (pcEn) begin
        done = 1'b1; wen_s = WEN; wsel_s = wsel; pcs_s = pcSel; rfin_s = rfInSel;
      end
      @(negedge CLK);
    end
    ihit = 1'b0; dhit = 1'b0;
    x = sb.pop_front();
    chk({tag, " retire"}, 32'(done), 32'd1);
    if (done) begin
      chk({tag, " latency"}, 32'(cyc), 32'(x.lat));
      chk({tag, " WEN"}, 32'(wen_s), 32'(x.wen));
      chk({tag, " WEN pulses"}, 32'(wenn), 32'(x.wen));
      chk({tag, " pcSel"}, 32'(pcs_s), 32'(x.pcsel));
      chk({tag, " mem cycles"}, 32'(memn), 32'(x.memn));
      if (x.wen) begin
        chk({tag, " wsel"}, 32'(wsel_s), 32'(x.wsel));
        chk({tag, " rfInSel"}, 32'(rfin_s), 32'(x.rfin));
      end
      if (x.ck_op) begin
        chk({tag, " op"}, 32'(op_s), 32'(x.op));
        chk({tag, " aluBSel"}, 32'(bsel_s), 32'(x.bsel));
      end
      if (x.ck_ext) chk({tag, " ext32"}, ext_s, x.ext);
    end
  endtask

  // Feeds a word that must halt the core; checks halt and quiet strobes afterwards
  task automatic run_halt(input string tag, input logic [31:0] word);
    int bad;
    ins = word; ihit = 1'b1;
    @(negedge CLK);
    ihit = 1'b0;
    @(negedge CLK);
    #1;
    chk({tag, " halt"}, 32'(halt), 32'd1);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      ihit = 1'b1;
      #1;
      if (iREN || pcEn || WEN || dREN || dWEN || !halt) bad++;
    end
    ihit = 1'b0;
    chk({tag, " quiet while halted"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int n_iren, n_dren, n_pcen;
    RST = 1'b1; ins = '0; ihit = 1'b0; dhit = 1'b0; zf = 1'b0;
    s_rsel1 = '0; s_rsel2 = '0; s_shamt = '0; s_imm = '0;

    do_reset();
    #1;
    chk("reset iREN", 32'(iREN), 32'd1);
    chk("reset halt", 32'(halt), 32'd0);
    chk("reset timeout", 32'(timeout), 32'd0);
    chk("reset strobes", {27'd0, pcEn, WEN, dREN, dWEN, 1'b0}, 32'd0);

    run_instr("ADDU", 32'h00221821, 1'b0, 0, mk(4, 1, 5'd3, PC_PC4, RF_ALU, 1, OP_ADD, B_RT, 0, 0, 0));
    chk("ADDU rsel1", 32'(s_rsel1), 32'd1);
    chk("ADDU rsel2", 32'(s_rsel2), 32'd2);
    run_instr("LW", 32'h8C220004, 1'b0, 3, mk(7, 1, 5'd2, PC_PC4, RF_MEM, 1, OP_ADD, B_EXT32, 1, 32'd4, 3));
    run_instr("BEQ taken", 32'h10210003, 1'b1, 0, mk(3, 0, 5'd0, PC_BRANCH, RF_ALU, 1, OP_SUB, B_RT, 0, 0, 0));
    run_instr("BEQ not", 32'h10210003, 1'b0, 0, mk(3, 0, 5'd0, PC_PC4, RF_ALU, 1, OP_SUB, B_RT, 0, 0, 0));
    run_instr("BNE taken", 32'h14210003, 1'b0, 0, mk(3, 0, 5'd0, PC_BRANCH, RF_ALU, 1, OP_SUB, B_RT, 0, 0, 0));
    run_instr("BNE not", 32'h14210003, 1'b1, 0, mk(3, 0, 5'd0, PC_PC4, RF_ALU, 1, OP_SUB, B_RT, 0, 0, 0));
    run_instr("SW", 32'hAC220008, 1'b0, 1, mk(4, 0, 5'd0, PC_PC4, RF_ALU, 1, OP_ADD, B_EXT32, 1, 32'd8, 1));
    run_instr("ADDI", 32'h2025FFFF, 1'b0, 0, mk(4, 1, 5'd5, PC_PC4, RF_ALU, 1, OP_ADD, B_EXT32, 1, 32'hFFFFFFFF, 0));
    run_instr("ORI", 32'h34268000, 1'b0, 0, mk(4, 1, 5'd6, PC_PC4, RF_ALU, 1, OP_OR, B_EXT32, 1, 32'h00008000, 0));
    run_instr("SLL", 32'h000220C0, 1'b0, 0, mk(4, 1, 5'd4, PC_PC4, RF_ALU, 1, OP_SLL, B_SHAMT, 0, 0, 0));
    chk("SLL shamt", s_shamt, 32'd3);
    run_instr("LUI", 32'h3C071234, 1'b0, 0, mk(4, 1, 5'd7, PC_PC4, RF_LUI, 0, 0, 0, 0, 0, 0));
    run_instr("ADDU r0", 32'h00220021, 1'b0, 0, mk(4, 1, 5'd0, PC_PC4, RF_ALU, 0, 0, 0, 0, 0, 0));
    run_instr("JAL", 32'h0C000010, 1'b0, 0, mk(4, 1, 5'd31, PC_JUMP, RF_PC4, 0, 0, 0, 0, 0, 0));
    run_instr("J", 32'h08000010, 1'b0, 0, mk(3, 0, 5'd0, PC_JUMP, RF_ALU, 0, 0, 0, 0, 0, 0));
    chk("J immJ26", 32'(s_imm), 32'h10);
    run_instr("JR", 32'h03E00008, 1'b0, 0, mk(3, 0, 5'd0, PC_JR, RF_ALU, 0, 0, 0, 0, 0, 0));
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    run_halt("HALT", 32'hFFFFFFFF);
    do_reset();
    #1;
    chk("post-halt reset halt", 32'(halt), 32'd0);
    chk("post-halt reset iREN", 32'(iREN), 32'd1);

    run_halt("bad opcode", 32'h7C000000);
    do_reset();
    run_halt("bad funct", 32'h0000003F);

    // fetch watchdog: eight unanswered fetch cycles, then halted with timeout
    do_reset();
    n_iren = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (iREN) n_iren++;
      @(negedge CLK);
    end
    #1;
    chk("fetch wd iREN cycles", 32'(n_iren), 32'd8);
    chk("fetch wd iREN after", 32'(iREN), 32'd0);
    chk("fetch wd timeout", 32'(timeout), 32'd1);
    chk("fetch wd halt", 32'(halt), 32'd1);
    do_reset();
    #1;
    chk("timeout cleared", 32'(timeout), 32'd0);

    // memory watchdog: LW whose dhit never arrives
    ins = 32'h8C220004;
    n_dren = 0; n_pcen = 0;
    for (int c = 1; c <= 16; c++) begin
      ihit = (c == 1);
      #1;
      if (dREN) n_dren++;
      if (pcEn) n_pcen++;
      @(negedge CLK);
    end
    ihit = 1'b0;
    #1;
    chk("mem wd dREN cycles", 32'(n_dren), 32'd8);
    chk("mem wd pcEn", 32'(n_pcen), 32'd0);
    chk("mem wd timeout", 32'(timeout), 32'd1);
    chk("mem wd dREN after", 32'(dREN), 32'd0);

    // reset during MEM of a store
    do_reset();
    ins = 32'hAC220008;
    n_pcen = 0;
    for (int c = 1; c <= 5; c++) begin
      ihit = (c == 1);
      #1;
      if (pcEn) n_pcen++;
      if (c >= 4) chk("SW MEM dWEN", 32'(dWEN), 32'd1);
      if (c < 5) @(negedge CLK);
    end
    ihit = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    #1;
    chk("rst mid-MEM dWEN", 32'(dWEN), 32'd0);
    chk("rst mid-MEM iREN", 32'(iREN), 32'd1);
    chk("rst mid-MEM pcEn", 32'(n_pcen + int'(pcEn)), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

`ifdef CU_PERF_CNT_EN
    do_reset();
    #1;
    chk("perf instret reset", instret, 32'd0);
    chk("perf cycles reset", cycles, 32'd0);
    for (int k = 0; k < 3; k++)
      run_instr("perf ADDU", 32'h00221821, 1'b0, 0, mk(4, 1, 5'd3, PC_PC4, RF_ALU, 1, OP_ADD, B_RT, 0, 0, 0));
    run_halt("perf HALT", 32'hFFFFFFFF);
    chk("perf instret", instret, 32'd3);
    chk("perf cycles", cycles, 32'd14);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
